// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped UART transmitter (8N1, LSB first) fed by a byte FIFO.
// Optional feature macro UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_dev #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [15:0] DIV_RESET    = 16'd433,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic [AddressWidth-1:0] addr_i,
    input  logic                    we_i,
    input  logic [DataWidth-1:0]    wdata_i,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    tx_o,
    output logic                    irq_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    logic [15:0] div;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_end;
    logic        busy;
    logic        tx_bit;
    logic        ovf;
    logic        pop;
    logic        push_req;
    logic        push;
    logic        drop;

    logic [1:0]           reg_sel;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [DataWidth-1:0] rd_val;

`ifdef UART_TX_PARITY_EN
    logic par_bit;
`endif

    logic unused_bits;
    assign unused_bits = ^{addr_i[AddressWidth-1:4], addr_i[1:0], wdata_i[DataWidth-1:16]};

    assign reg_sel  = addr_i[3:2];
    assign wr_acc   = req_i & we_i;
    assign rd_acc   = req_i & ~we_i;
    assign empty    = (count == '0);
    assign full     = (count == DEPTH);
    assign bit_end  = (cnt == '0);
    assign push_req = wr_acc & (reg_sel == 2'd0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // FIFO storage and pointers
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // TX FSM: state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // TX FSM: next state and pop request
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // TX FSM: outputs
    always_comb begin
        busy   = (state != ST_IDLE);
        tx_bit = 1'b1;
        case (state)
            ST_START: tx_bit = 1'b0;
            ST_DATA:  tx_bit = shreg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_bit = par_bit;
`endif
            default:  tx_bit = 1'b1;
        endcase
    end

    assign tx_o = tx_bit;

    // Bit timing and shifter; DIV is sampled only when a new bit starts.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else if (pop) begin
            cnt     <= div;
            bit_idx <= '0;
            shreg   <= fifo_mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            par_bit <= ^fifo_mem[rd_ptr];
`endif
        end else if (state != ST_IDLE) begin
            if (bit_end) begin
                cnt <= div;
                if (state == ST_DATA) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                cnt <= cnt - 16'd1;
            end
        end
    end

    // Register read mux; count sits at [15:8] and only spills past bit 15 for a 256-deep FIFO.
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            2'd1: begin
                rd_val[0]       = busy;
                rd_val[1]       = full;
                rd_val[2]       = empty;
                rd_val[3]       = ovf;
                rd_val[4]       = PARITY_EN;
                rd_val[8 +: CW] = count;
            end
            2'd2:    rd_val[15:0] = div;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            div     <= DIV_RESET;
            ovf     <= 1'b0;
            rdata_o <= '0;
            irq_o   <= 1'b1;
        end else begin
            if (drop) begin
                ovf <= 1'b1;
            end else if (wr_acc && reg_sel == 2'd1 && wdata_i[3]) begin
                ovf <= 1'b0;
            end
            if (wr_acc && reg_sel == 2'd2) begin
                div <= wdata_i[15:0];
            end
            if (rd_acc) begin
                rdata_o <= rd_val;
            end
            irq_o <= empty & ~busy;
        end
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: directed register vectors plus captured tx_o streams compared against expected frames.
module tb_uart_tx_dev;

`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] PAR_FLAG = 32'h10;
    localparam int unsigned NB = 11;
`else
    localparam logic [31:0] PAR_FLAG = 32'h0;
    localparam int unsigned NB = 10;
`endif

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    logic        cap_on = 1'b0;
    logic        cap [$];
    logic        exp_bits [$];

    uart_tx_dev #(
        .FIFO_DEPTH  (16),
        .DIV_RESET   (16'd433),
        .DataWidth   (32),
        .AddressWidth(32)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .req_i  (req),
        .addr_i (addr),
        .we_i   (we),
        .wdata_i(wdata),
        .rdata_o(rdata),
        .tx_o   (tx),
        .irq_o  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (cap_on) cap.push_back(tx);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        req = 1'b0;
        d = rdata;
    endtask

    task automatic add_frame(input logic [7:0] b);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        exp_bits.push_back(^b);
`endif
        exp_bits.push_back(1'b1);
    endtask

    function automatic int first_zero();
        for (int i = 0; i < cap.size(); i++) begin
            if (cap[i] === 1'b0) return i;
        end
        return -1;
    endfunction

    function automatic int last_zero();
        for (int i = cap.size() - 1; i >= 0; i--) begin
            if (cap[i] === 1'b0) return i;
        end
        return -1;
    endfunction

    task automatic check_stream(input string name, input int start, input int unsigned period);
        for (int b = 0; b < exp_bits.size(); b++) begin
            logic seen;
            seen = exp_bits[b];
            for (int unsigned k = 0; k < period; k++) begin
                int idx;
                idx = start + b * int'(period) + int'(k);
                if (idx < 0 || idx >= cap.size()) seen = 1'bx;
                else if (cap[idx] !== exp_bits[b]) seen = cap[idx];
            end
            check($sformatf("%s bit%0d", name, b), {31'b0, seen}, {31'b0, exp_bits[b]});
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          start;
        int unsigned t0;
        int unsigned target;
        int unsigned guard;

        vecs[0] = '{32'h4, 1'b0, 32'h0,         32'h4 | PAR_FLAG};
        vecs[1] = '{32'h8, 1'b0, 32'h0,         32'h1B1};
        vecs[2] = '{32'h0, 1'b0, 32'h0,         32'h0};
        vecs[3] = '{32'h8, 1'b1, 32'h0001_0005, 32'h0};
        vecs[4] = '{32'h8, 1'b0, 32'h0,         32'h5};
        vecs[5] = '{32'hC, 1'b1, 32'hFFFF_FFFF, 32'h0};
        vecs[6] = '{32'hC, 1'b0, 32'h0,         32'h0};
        vecs[7] = '{32'h8, 1'b0, 32'h0,         32'h5};
        vecs[8] = '{32'h4, 1'b1, 32'h8,         32'h0};
        vecs[9] = '{32'h4, 1'b0, 32'h0,         32'h4 | PAR_FLAG};

        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("reset tx", {31'b0, tx}, 32'h1);
        check("reset irq", {31'b0, irq}, 32'h1);
        check("reset rdata", rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // register map vectors
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d rd@0x%0h", i, vecs[i].addr), rd, vecs[i].exp);
            end
        end
        repeat (2) @(negedge clk);
        check("rdata hold", rdata, 32'h4 | PAR_FLAG);

        // single frame, DIV=3
        bus_write(32'h8, 32'd3);
        check("t1 irq idle", {31'b0, irq}, 32'h1);
        cap.delete(); cap_on = 1'b1;
        bus_write(32'h0, 32'hA5);
        repeat (2) @(negedge clk);
        check("t1 irq busy", {31'b0, irq}, 32'h0);
        repeat (53) @(negedge clk);
        cap_on = 1'b0;
        exp_bits.delete(); add_frame(8'hA5); exp_bits.push_back(1'b1);
        start = first_zero();
        check("t1 start latency", start, 32'd1);
        if (start < 0) start = 1;
        check_stream("t1", start, 4);
        check("t1 irq end", {31'b0, irq}, 32'h1);

        // back-to-back frames, DIV=0
        bus_write(32'h8, 32'd0);
        cap.delete(); cap_on = 1'b1;
        bus_write(32'h0, 32'h07);
        bus_write(32'h0, 32'h81);
        bus_write(32'h0, 32'hF0);
        repeat (40) @(negedge clk);
        cap_on = 1'b0;
        exp_bits.delete();
        add_frame(8'h07); add_frame(8'h81); add_frame(8'hF0);
        exp_bits.push_back(1'b1); exp_bits.push_back(1'b1);
        start = first_zero();
        check("t2 start latency", start, 32'd1);
        if (start < 0) start = 1;
        check_stream("t2", start, 1);
        bus_read(32'h4, rd);
        check("t2 status empty", rd, 32'h4 | PAR_FLAG);

        // fill FIFO, overflow, clear ovf
        bus_write(32'h8, 32'd100);
        t0 = cyc;
        for (int i = 0; i < 17; i++) bus_write(32'h0, 32'h10 + i);
        bus_read(32'h4, rd);
        check("t3 full", rd, 32'h1003 | PAR_FLAG);
        bus_write(32'h0, 32'hEE);
        bus_read(32'h4, rd);
        check("t3 ovf", rd, 32'h100B | PAR_FLAG);
        bus_write(32'h4, 32'h8);
        bus_read(32'h4, rd);
        check("t3 ovf clear", rd, 32'h1003 | PAR_FLAG);

        // push exactly on the posedge where the first frame ends and the next is popped
        target = t0 + 1 + NB * 101;
        while (cyc < target) @(negedge clk);
        bus_write(32'h0, 32'h5B);
        check("t4 next start", {31'b0, tx}, 32'h0);
        bus_read(32'h4, rd);
        check("t4 count kept", rd, 32'h1003 | PAR_FLAG);

        cap.delete(); cap_on = 1'b1;
        bus_write(32'h8, 32'd0);
        guard = 0;
        while (irq !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("t4 drain irq", {31'b0, irq}, 32'h1);
        repeat (4) @(negedge clk);
        cap_on = 1'b0;
        start = last_zero() - 8;
        check("t4 last frame found", {31'b0, start >= 0}, 32'h1);
        if (start < 0) start = 0;
        exp_bits.delete(); add_frame(8'h5B);
        exp_bits.push_back(1'b1); exp_bits.push_back(1'b1);
        check_stream("t4 last", start, 1);
        bus_read(32'h4, rd);
        check("t4 status empty", rd, 32'h4 | PAR_FLAG);

        // asynchronous reset mid-frame
        bus_write(32'h8, 32'd3);
        bus_write(32'h0, 32'h00);
        bus_write(32'h0, 32'h00);
        repeat (6) @(negedge clk);
        check("t6 mid data tx", {31'b0, tx}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async tx", {31'b0, tx}, 32'h1);
        check("t6 async irq", {31'b0, irq}, 32'h1);
        check("t6 async rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(32'h4, rd);
        check("t6 status", rd, 32'h4 | PAR_FLAG);
        bus_read(32'h8, rd);
        check("t6 div reset", rd, 32'h1B1);
        repeat (10) @(negedge clk);
        check("t6 tx idle", {31'b0, tx}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
